// File: rtl/addr8u_sweep_checker.sv
// ----------------------------------------------------------------------------
// addr8u_sweep_checker
//
// Purpose:
//   Exhaustive stimulus generator and result checker for 8-bit unsigned
//   adder netlists. Every (A,B) operand pair, 65536 in total, is driven into
//   the adder under test, and the 9-bit sum that comes back is compared with
//   A+B. The block keeps a mismatch count and remembers the first failing
//   vector.
//
//   The checker sits on both sides of the adder. o_op_a/o_op_b feed the
//   adder's A/B pins, and the adder's O[8:0] returns on i_dut_sum.
//
// Parameters:
//   DUT_LAT  register stages inside the adder path (0 = combinational), 0..3
//   ERR_W    width of o_err_count, >= 17 so that 65536 errors fit
//
// Ports:
//   i_clk              rising-edge clock
//   i_rst_n            asynchronous active-low reset
//   i_start            begin a sweep (honoured only when idle or done)
//   o_op_a, o_op_b     registered operands to the adder under test
//   i_dut_sum          adder result O[8:0]
//   o_busy             sweep or drain in progress
//   o_done             last sweep complete, results stable
//   o_mismatch         one-cycle pulse per wrong result (registered)
//   o_err_count        mismatching vectors in the current/last sweep
//   o_first_err_valid  at least one mismatch seen in this sweep
//   o_first_err_a/b    operands of the first mismatch
//   o_first_err_sum    adder result captured at the first mismatch
// ----------------------------------------------------------------------------
module addr8u_sweep_checker #(
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 17
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic [7:0]       o_op_a,
    output logic [7:0]       o_op_b,
    input  logic [8:0]       i_dut_sum,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_mismatch,
    output logic [ERR_W-1:0] o_err_count,
    output logic             o_first_err_valid,
    output logic [7:0]       o_first_err_a,
    output logic [7:0]       o_first_err_b,
    output logic [8:0]       o_first_err_sum
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SWEEP = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] LAT_CNT  = 2'(DUT_LAT);

    logic [1:0]       r_state;
    logic [15:0]      r_idx;
    logic [7:0]       r_opA;
    logic [7:0]       r_opB;
    logic             r_issueValid;
    logic [1:0]       r_drainCnt;
    logic             r_done;

    logic             r_mismatch;
    logic [ERR_W-1:0] r_errCount;
    logic             r_firstValid;
    logic [7:0]       r_firstA;
    logic [7:0]       r_firstB;
    logic [8:0]       r_firstSum;

    logic             w_startAccept;
    logic [7:0]       w_aD;
    logic [7:0]       w_bD;
    logic             w_validD;
    logic [8:0]       w_expected;
    logic             w_bad;

    // A start request only counts while no sweep is in flight.
    assign w_startAccept = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Sweep sequencer. Each SWEEP cycle registers the next (A,B) pair onto the
    // operand outputs together with an issue-valid flag. The drain phase
    // covers DUT_LAT cycles of adder pipeline plus the one cycle in which the
    // final compare result is registered. Because of that extra cycle, done
    // only rises once the error count is final.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= 16'h0000;
            r_opA        <= 8'h00;
            r_opB        <= 8'h00;
            r_issueValid <= 1'b0;
            r_drainCnt   <= 2'd0;
            r_done       <= 1'b0;
        end else begin
            r_issueValid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state <= ST_SWEEP;
                        r_idx   <= 16'h0000;
                        r_done  <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    r_opA        <= r_idx[15:8];
                    r_opB        <= r_idx[7:0];
                    r_issueValid <= 1'b1;
                    r_idx        <= r_idx + 16'd1;
                    // The 16'hFFFF -> 0 rollover ends the sweep.
                    if (r_idx == 16'hFFFF) begin
                        r_state    <= ST_DRAIN;
                        r_drainCnt <= 2'd0;
                    end
                end
                ST_DRAIN: begin
                    if (r_drainCnt == LAT_CNT) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drainCnt <= r_drainCnt + 2'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Delay line that lines up each issued vector with the adder result it
    // produces. With DUT_LAT = 0 the adder is combinational, so the operand
    // registers themselves are the aligned copy.
    generate
        if (DUT_LAT == 0) begin : g_noDelay
            assign w_aD     = r_opA;
            assign w_bD     = r_opB;
            assign w_validD = r_issueValid;
        end else begin : g_delay
            logic [7:0] r_dA [DUT_LAT];
            logic [7:0] r_dB [DUT_LAT];
            logic       r_dV [DUT_LAT];

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int i = 0; i < DUT_LAT; i++) begin
                        r_dA[i] <= 8'h00;
                        r_dB[i] <= 8'h00;
                        r_dV[i] <= 1'b0;
                    end
                end else begin
                    r_dA[0] <= r_opA;
                    r_dB[0] <= r_opB;
                    r_dV[0] <= r_issueValid;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        r_dA[i] <= r_dA[i-1];
                        r_dB[i] <= r_dB[i-1];
                        r_dV[i] <= r_dV[i-1];
                    end
                end
            end

            assign w_aD     = r_dA[DUT_LAT-1];
            assign w_bD     = r_dB[DUT_LAT-1];
            assign w_validD = r_dV[DUT_LAT-1];
        end
    endgenerate

    // The reference sum is computed 9 bits wide so that the carry is kept.
    // The adder's output is qualified by the aligned valid, so any garbage it
    // shows outside compare cycles is ignored.
    assign w_expected = {1'b0, w_aD} + {1'b0, w_bD};
    assign w_bad      = w_validD && (i_dut_sum != w_expected);

    // Result bookkeeping. An accepted start wipes the previous sweep's
    // results. The error count stops at all-ones rather than wrapping. The
    // first failing vector is latched once and then held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mismatch   <= 1'b0;
            r_errCount   <= '0;
            r_firstValid <= 1'b0;
            r_firstA     <= 8'h00;
            r_firstB     <= 8'h00;
            r_firstSum   <= 9'h000;
        end else if (w_startAccept) begin
            r_mismatch   <= 1'b0;
            r_errCount   <= '0;
            r_firstValid <= 1'b0;
            r_firstA     <= 8'h00;
            r_firstB     <= 8'h00;
            r_firstSum   <= 9'h000;
        end else begin
            r_mismatch <= w_bad;
            if (w_bad) begin
                if (r_errCount != {ERR_W{1'b1}}) begin
                    r_errCount <= r_errCount + ERR_W'(1);
                end
                if (!r_firstValid) begin
                    r_firstValid <= 1'b1;
                    r_firstA     <= w_aD;
                    r_firstB     <= w_bD;
                    r_firstSum   <= i_dut_sum;
                end
            end
        end
    end

    assign o_op_a            = r_opA;
    assign o_op_b            = r_opB;
    assign o_busy            = (r_state == ST_SWEEP) || (r_state == ST_DRAIN);
    assign o_done            = r_done;
    assign o_mismatch        = r_mismatch;
    assign o_err_count       = r_errCount;
    assign o_first_err_valid = r_firstValid;
    assign o_first_err_a     = r_firstA;
    assign o_first_err_b     = r_firstB;
    assign o_first_err_sum   = r_firstSum;

endmodule

// File: tb/tb_addr8u_sweep_checker.sv
// ----------------------------------------------------------------------------
// tb_addr8u_sweep_checker
//
// Five checkers share one clock, reset and start. Each drives its own
// reference adder model:
//   0: exact combinational adder, DUT_LAT=0
//   1: combinational adder with sum[8] stuck at 0, DUT_LAT=0
//   2: combinational adder with sum[0] stuck at 1, DUT_LAT=0
//   3: two-stage registered adder, DUT_LAT=2
//   4: the same two-stage adder, checked with DUT_LAT=1 (misaligned)
// ----------------------------------------------------------------------------
module tb_addr8u_sweep_checker;

    typedef struct {
        string      name;
        int         expErr;
        logic       expFev;
        logic [7:0] expA;
        logic [7:0] expB;
        logic [8:0] expSum;
        int         expCycles;
    } expRec_t;

    logic        clk;
    logic        rst_n;
    logic        start;

    logic [7:0]  opA    [5];
    logic [7:0]  opB    [5];
    logic [8:0]  sumIn  [5];
    logic        busy   [5];
    logic        done   [5];
    logic        mism   [5];
    logic [16:0] errCnt [5];
    logic        fev    [5];
    logic [7:0]  fea    [5];
    logic [7:0]  feb    [5];
    logic [8:0]  fes    [5];

    logic [8:0]  p3s1, p3s2, p4s1, p4s2;

    int          checks;
    int          errors;
    int          doneCyc [5];
    expRec_t     expTab  [5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference adders driven from each checker's operand outputs.
    assign sumIn[0] = {1'b0, opA[0]} + {1'b0, opB[0]};
    assign sumIn[1] = ({1'b0, opA[1]} + {1'b0, opB[1]}) & 9'h0FF;
    assign sumIn[2] = ({1'b0, opA[2]} + {1'b0, opB[2]}) | 9'h001;
    assign sumIn[3] = p3s2;
    assign sumIn[4] = p4s2;

    always_ff @(posedge clk) begin
        p3s1 <= {1'b0, opA[3]} + {1'b0, opB[3]};
        p3s2 <= p3s1;
        p4s1 <= {1'b0, opA[4]} + {1'b0, opB[4]};
        p4s2 <= p4s1;
    end

    addr8u_sweep_checker #(.DUT_LAT(0), .ERR_W(17)) u_chk0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_op_a(opA[0]), .o_op_b(opB[0]), .i_dut_sum(sumIn[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_mismatch(mism[0]),
        .o_err_count(errCnt[0]), .o_first_err_valid(fev[0]),
        .o_first_err_a(fea[0]), .o_first_err_b(feb[0]), .o_first_err_sum(fes[0]));

    addr8u_sweep_checker #(.DUT_LAT(0), .ERR_W(17)) u_chk1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_op_a(opA[1]), .o_op_b(opB[1]), .i_dut_sum(sumIn[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_mismatch(mism[1]),
        .o_err_count(errCnt[1]), .o_first_err_valid(fev[1]),
        .o_first_err_a(fea[1]), .o_first_err_b(feb[1]), .o_first_err_sum(fes[1]));

    addr8u_sweep_checker #(.DUT_LAT(0), .ERR_W(17)) u_chk2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_op_a(opA[2]), .o_op_b(opB[2]), .i_dut_sum(sumIn[2]),
        .o_busy(busy[2]), .o_done(done[2]), .o_mismatch(mism[2]),
        .o_err_count(errCnt[2]), .o_first_err_valid(fev[2]),
        .o_first_err_a(fea[2]), .o_first_err_b(feb[2]), .o_first_err_sum(fes[2]));

    addr8u_sweep_checker #(.DUT_LAT(2), .ERR_W(17)) u_chk3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_op_a(opA[3]), .o_op_b(opB[3]), .i_dut_sum(sumIn[3]),
        .o_busy(busy[3]), .o_done(done[3]), .o_mismatch(mism[3]),
        .o_err_count(errCnt[3]), .o_first_err_valid(fev[3]),
        .o_first_err_a(fea[3]), .o_first_err_b(feb[3]), .o_first_err_sum(fes[3]));

    addr8u_sweep_checker #(.DUT_LAT(1), .ERR_W(17)) u_chk4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_op_a(opA[4]), .o_op_b(opB[4]), .i_dut_sum(sumIn[4]),
        .o_busy(busy[4]), .o_done(done[4]), .o_mismatch(mism[4]),
        .o_err_count(errCnt[4]), .o_first_err_valid(fev[4]),
        .o_first_err_a(fea[4]), .o_first_err_b(feb[4]), .o_first_err_sum(fes[4]));

    // One comparison. Every failure prints a single line.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives the shared start line.
    task automatic applyStimulus(input logic s);
        start = s;
    endtask

    initial begin
        int  c;
        bit  allDone;

        checks = 0;
        errors = 0;
        for (int i = 0; i < 5; i++) doneCyc[i] = 0;

        // Expected final results, hand-derived:
        //  sum[8] stuck-0 fails on every pair with A+B >= 256 (32640 pairs).
        //  sum[0] stuck-1 fails on every even sum (32768 pairs).
        //  In the misaligned case each vector k>=1 is compared with sum(k-1),
        //  and consecutive sums always differ, so 65535 mismatches occur.
        expTab[0] = '{"exact_lat0", 0,     1'b0, 8'h00, 8'h00, 9'h000, 65537};
        expTab[1] = '{"sum8_sa0",   32640, 1'b1, 8'h01, 8'hFF, 9'h000, 65537};
        expTab[2] = '{"sum0_sa1",   32768, 1'b1, 8'h00, 8'h00, 9'h001, 65537};
        expTab[3] = '{"pipe2_lat2", 0,     1'b0, 8'h00, 8'h00, 9'h000, 65539};
        expTab[4] = '{"pipe2_lat1", 65535, 1'b1, 8'h00, 8'h01, 9'h000, 65538};

        // Reset values.
        rst_n = 1'b0;
        applyStimulus(1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset op_a",   {24'h0, opA[0]},   32'h0);
        checkOutput("reset op_b",   {24'h0, opB[0]},   32'h0);
        checkOutput("reset busy",   {31'h0, busy[0]},  32'h0);
        checkOutput("reset done",   {31'h0, done[0]},  32'h0);
        checkOutput("reset err",    {15'h0, errCnt[0]}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start a sweep, then pull reset asynchronously part-way through.
        @(posedge clk);
        #1;
        applyStimulus(1'b1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0);
        checkOutput("busy after start", {31'h0, busy[0]}, 32'h1);
        repeat (300) @(posedge clk);
        #1;
        checkOutput("sa1 errors before reset", {31'h0, (errCnt[2] != 17'h0)}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset busy",   {31'h0, busy[0]},   32'h0);
        checkOutput("midreset op",     {16'h0, opA[0], opB[0]}, 32'h0);
        checkOutput("midreset err sa1", {15'h0, errCnt[2]}, 32'h0);
        checkOutput("midreset fev sa1", {31'h0, fev[2]},    32'h0);
        checkOutput("midreset fes sa1", {23'h0, fes[2]},    32'h0);
        checkOutput("midreset mism sa1", {31'h0, mism[2]},  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Full sweep on all five checkers at once.
        applyStimulus(1'b1);
        @(posedge clk);
        c = 0;
        allDone = 1'b0;
        while (!allDone && c < 70000) begin
            @(posedge clk);
            c++;
            #1;
            // A start pulse mid-sweep must be ignored.
            applyStimulus(c == 1000);
            for (int i = 0; i < 5; i++) begin
                if (done[i] && doneCyc[i] == 0) doneCyc[i] = c;
            end
            if (c == 2) begin
                checkOutput("sa1 mismatch pulse", {31'h0, mism[2]},   32'h1);
                checkOutput("sa1 err after v0",   {15'h0, errCnt[2]}, 32'h1);
            end
            if (c == 3) begin
                checkOutput("sa1 mismatch drop", {31'h0, mism[2]}, 32'h0);
            end
            if (c == 5) begin
                checkOutput("op index c5", {16'h0, opA[0], opB[0]}, 32'd4);
            end
            if (c == 512) begin
                checkOutput("sa0 quiet before 0x1FF", {15'h0, errCnt[1]}, 32'h0);
            end
            if (c == 513) begin
                checkOutput("sa0 mismatch at 0x1FF", {31'h0, mism[1]}, 32'h1);
            end
            if (c == 1002) begin
                checkOutput("busy after ignored start", {31'h0, busy[0]}, 32'h1);
                checkOutput("op continues after start", {16'h0, opA[0], opB[0]}, 32'd1001);
            end
            allDone = 1'b1;
            for (int i = 0; i < 5; i++) begin
                if (doneCyc[i] == 0) allDone = 1'b0;
            end
        end
        applyStimulus(1'b0);
        checkOutput("sweep timeout", {31'h0, allDone}, 32'h1);

        // Final results per checker, compared from the expectation table.
        for (int i = 0; i < 5; i++) begin
            checkOutput({expTab[i].name, " err_count"}, {15'h0, errCnt[i]}, expTab[i].expErr);
            checkOutput({expTab[i].name, " first_valid"}, {31'h0, fev[i]}, {31'h0, expTab[i].expFev});
            checkOutput({expTab[i].name, " first_a"}, {24'h0, fea[i]}, {24'h0, expTab[i].expA});
            checkOutput({expTab[i].name, " first_b"}, {24'h0, feb[i]}, {24'h0, expTab[i].expB});
            checkOutput({expTab[i].name, " first_sum"}, {23'h0, fes[i]}, {23'h0, expTab[i].expSum});
            checkOutput({expTab[i].name, " done cycle"}, doneCyc[i], expTab[i].expCycles);
            checkOutput({expTab[i].name, " busy at end"}, {31'h0, busy[i]}, 32'h0);
        end

        // Start held in DONE restarts immediately and clears the results.
        applyStimulus(1'b1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0);
        checkOutput("restart done cleared", {31'h0, done[1]},   32'h0);
        checkOutput("restart busy",         {31'h0, busy[1]},   32'h1);
        checkOutput("restart err cleared",  {15'h0, errCnt[1]}, 32'h0);
        checkOutput("restart fev cleared",  {31'h0, fev[1]},    32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
